// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction prefetch unit.
//   FETCH_AW / FETCH_DW / FETCH_DEPTH / FETCH_RESET_PC : default parameters
//   fetch_entry_t  : one queued instruction {instr, pc, npc}
//   fetch_state_t  : request tracker state (idle / waiting / waiting-to-drop)
// The entry fields are sized from FETCH_AW / FETCH_DW, so instances must keep
// AW and DW at these values.
package fetch_pkg;

  localparam int FETCH_AW    = 16;
  localparam int FETCH_DW    = 16;
  localparam int FETCH_DEPTH = 4;
  localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = 16'h3000;

  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_AW-1:0] npc;
  } fetch_entry_t;

  // FS_DROP: a redirect happened while a response was in flight; that
  // response must be swallowed when it arrives.
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_BUSY = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if -- memory request bus plus the instruction output stream.
//   instrmem_rd / imem_addr       : read strobe and address (prefetcher -> memory)
//   imem_rdata / imem_valid       : returned instruction (memory -> prefetcher)
//   instr_valid / instr / instr_pc / instr_npc : queue head (prefetcher -> consumer)
//   instr_ready                   : consumer accepts the head
// master = prefetcher side, slave = memory/consumer side.
interface fetch_prefetch_if
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_AW,
  parameter int DW = FETCH_DW
);
  logic          instrmem_rd;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_valid;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] instr_npc;

  modport master (
    output instrmem_rd, imem_addr, instr_valid, instr, instr_pc, instr_npc,
    input  imem_rdata, imem_valid, instr_ready
  );

  modport slave (
    input  instrmem_rd, imem_addr, instr_valid, instr, instr_pc, instr_npc,
    output imem_rdata, imem_valid, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo -- synchronous FIFO of fetch_entry_t, DEPTH entries.
//   clk, rst : clock, synchronous active-high reset
//   flush    : empties the queue (pointers and count to zero)
//   push/wdata, pop : write and read-advance requests
//   rdata    : current head entry, count : occupancy, empty : count == 0
// The head is read combinationally from the array so that an entry written
// on one edge is visible at the head in the very next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push & ((count_reg != CNT_MAX) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch -- instruction prefetcher with a DEPTH-entry queue.
//   clk, rst         : clock, synchronous active-high reset
//   enable_fetch     : permits new memory requests
//   br_taken, taddr  : one-cycle redirect pulse and its target
//   bus (master)     : memory request/response and instruction output stream
//   pc, npc          : next fetch address and pc + 1
// One memory request may be in flight. A queue slot is reserved for it, so a
// response can always be pushed. A redirect flushes the queue; a response
// still in flight at that point is discarded when it arrives.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int            AW       = FETCH_AW,
  parameter int            DW       = FETCH_DW,
  parameter int            DEPTH    = FETCH_DEPTH,
  parameter logic [AW-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_fetch,
  input  logic                   br_taken,
  input  logic [AW-1:0]          taddr,
  fetch_prefetch_if.master       bus,
  output logic [AW-1:0]          pc,
  output logic [AW-1:0]          npc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] PC_ONE    = AW'(1);

  fetch_state_t  state_reg, state_next;
  logic          outstanding, drop;
  logic [AW-1:0] pc_reg, pc_next, req_pc_reg, req_pc_next;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          fifo_empty, issue, push, pop;
  fetch_entry_t  push_entry, head_entry;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FS_IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
    end
  end

  // Next-state logic. A response and a redirect in the same cycle consume the
  // response (it is simply not pushed), so no drop is pending afterwards.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FS_IDLE: if (issue) state_next = FS_BUSY;
      FS_BUSY: begin
        if (bus.imem_valid)  state_next = FS_IDLE;
        else if (br_taken)   state_next = FS_DROP;
      end
      FS_DROP: if (bus.imem_valid) state_next = FS_IDLE;
      default: state_next = FS_IDLE;
    endcase
  end

  // State decode
  always_comb begin
    outstanding = (state_reg != FS_IDLE);
    drop        = (state_reg == FS_DROP);
  end

  assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign issue     = enable_fetch & ~br_taken & ~outstanding & (occupancy < DEPTH_OCC);
  // Stray responses (nothing outstanding) fall through: push needs outstanding.
  assign push      = bus.imem_valid & outstanding & ~drop & ~br_taken;
  assign pop       = bus.instr_valid & bus.instr_ready & ~br_taken;

  always_comb begin
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    if (br_taken) begin
      pc_next = taddr;
    end else if (issue) begin
      pc_next     = pc_reg + PC_ONE;
      req_pc_next = pc_reg;
    end
  end

  assign push_entry = '{instr: bus.imem_rdata, pc: req_pc_reg, npc: req_pc_reg + PC_ONE};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (br_taken),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (count),
    .empty (fifo_empty)
  );

  assign bus.instrmem_rd = issue & ~rst;
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = ~fifo_empty;
  assign bus.instr       = head_entry.instr;
  assign bus.instr_pc    = head_entry.pc;
  assign bus.instr_npc   = head_entry.npc;
  assign pc              = pc_reg;
  assign npc             = pc_reg + PC_ONE;

  // Properties
  a_rise_issue: assert property (@(posedge clk) disable iff (rst)
    $rose(enable_fetch) && !br_taken && !outstanding && (occupancy < DEPTH_OCC)
      |-> $rose(bus.instrmem_rd));
  a_reset_pc:   assert property (@(posedge clk) rst |=> (pc_reg == RESET_PC));
  a_no_ovf:     assert property (@(posedge clk) count <= DEPTH_OCC[CW-1:0]);
endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AW, 16, address/PC width.
- DW, 16, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, >=2.
- RESET_PC, 16'h3000, PC value loaded on reset (AW bits).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- enable_fetch  in  1  permits new memory requests.
- br_taken  in  1  redirect request (one-cycle pulse).
- taddr  in  AW  redirect target.
- instrmem_rd  out  1  memory read strobe.
- imem_addr  out  AW  request address; equals pc.
- imem_rdata  in  DW  returned instruction.
- imem_valid  in  1  imem_rdata valid this cycle.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  consumer accepts head.
- instr  out  DW  head instruction.
- instr_pc  out  AW  head fetch address.
- instr_npc  out  AW  head fetch address + 1.
- pc  out  AW  next fetch address.
- npc  out  AW  pc + 1.

Function
REQ-003 npc SHALL equal pc+1 modulo 2^AW; 16'hFFFF wraps to 16'h0000.
REQ-004 issue = enable_fetch & !br_taken & !outstanding & (count + outstanding < DEPTH).
REQ-005 instrmem_rd SHALL equal issue combinationally, so a rising enable_fetch with space available raises instrmem_rd in the same cycle.
REQ-006 On issue, req_pc SHALL latch pc, pc SHALL advance to npc, and outstanding SHALL set.
REQ-007 At most one request SHALL be outstanding; outstanding SHALL clear on the edge that samples imem_valid=1.
REQ-008 imem_valid with outstanding=1 and drop=0 SHALL push {imem_rdata, req_pc, req_pc+1} into the queue.
REQ-009 Pushed data SHALL appear at the queue head with instr_valid=1 one cycle after imem_valid, provided the queue was empty.
REQ-010 instr_valid SHALL equal (count != 0).
REQ-011 A pop occurs when instr_valid & instr_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-012 The queue SHALL never overflow; REQ-004 reserves a slot for the outstanding response.
REQ-013 imem_valid with outstanding=0 SHALL be ignored.
REQ-014 br_taken=1 SHALL set pc to taddr, set count to 0, and suppress issue and pop in that cycle.
REQ-015 br_taken=1 with a request outstanding, or with imem_valid=1 in the same cycle, SHALL set drop=1 when the response is still pending.
REQ-016 The response arriving while drop=1 SHALL be discarded, clearing drop and outstanding.
REQ-017 The first issue after a redirect SHALL occur no earlier than the cycle after br_taken, and only once outstanding=0.
REQ-018 Queue ordering SHALL be FIFO; head pointers SHALL wrap modulo DEPTH.

Reset
REQ-019 While rst=1: pc=RESET_PC, count=0, outstanding=0, drop=0, pointers=0, and instrmem_rd=0 regardless of other inputs.
REQ-020 One cycle after rst deasserts, pc SHALL read RESET_PC and instr_valid SHALL read 0.
REQ-021 rst mid-operation SHALL abandon any outstanding response; a later stray imem_valid is ignored per REQ-013.

Structure
REQ-022 Package fetch_pkg SHALL hold the AW/DW/DEPTH/RESET_PC defaults and typedef fetch_entry_t {instr, pc, npc}.
REQ-023 Sub-module fetch_fifo (synchronous FIFO of fetch_entry_t, DEPTH entries, flush input) SHALL hold the queue.

Verification
REQ-024 Reset check: rst high 2 cycles, then low -> pc=16'h3000 and npc=16'h3001 next cycle; instrmem_rd=0 during reset.
REQ-025 Sequential fetch: enable_fetch=1, memory answers 1 cycle later with 16'h1111, 16'h2222, ..., instr_ready=1 -> instrs in order with instr_pc=3000, 3001, ..., and instrmem_rd high at most every other cycle.
REQ-026 Full queue: instr_ready=0, DEPTH=4 -> exactly 4 requests issued and instrmem_rd held 0 afterwards; one pop -> one new request.
REQ-027 Redirect with request outstanding: br_taken=1, taddr=16'h4000 -> queue empties and the late response is dropped; next imem_addr=16'h4000 and the first delivered instr_pc=16'h4000.
REQ-028 Wrap: rst with RESET_PC=16'hFFFF -> first entry has instr_pc=16'hFFFF and instr_npc=16'h0000; the second request has imem_addr=16'h0000.
REQ-029 Concurrent assertions: $rose(enable_fetch) & space -> $rose(instrmem_rd); rst |-> ##1 pc==RESET_PC; never count>DEPTH.
